fpnew_rr_arbiter: RTL and testbench

- Shares one FPNewBlackbox instance between NUM_REQ independent requesters (e.g. scalar lanes or issue ports).
- Round-robin arbitration on the input side; the FPU tag carries the requester index.
- Responses are routed back by tag. A per-requester outstanding-credit limit keeps one slow consumer from clogging the shared pipeline.
- Sits directly between the requesters and the FPU's in/out valid-ready handshakes.

---
 rtl/fpnew_rr_arbiter.sv | 227 ++++++++++++++++++++++
 tb/tb_fpnew_rr_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpnew_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fpnew_rr_arbiter
// Description : Shares one FPNew instance between NUM_REQ requesters.
//               Round-robin grant on the input handshake, the FPU tag carries
//               the requester index, responses are routed back by tag, and a
//               per-requester outstanding-operation limit keeps one stalled
//               consumer from filling the shared pipeline.
//               Optional macro FPNEW_ARB_PERF_EN adds per-requester grant and
//               stall event counters (perf_grant_o / perf_stall_o).
// Revision    : 1.0 - initial release
// ============================================================================
module fpnew_rr_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned REQ_W     = 200,
    parameter int unsigned RES_W     = 69,
    parameter int unsigned MAX_OUTST = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    input  logic [NUM_REQ*REQ_W-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]         resp_valid_o,
    input  logic [NUM_REQ-1:0]         resp_ready_i,
    output logic [RES_W-1:0]           resp_data_o,
    input  logic                       flush_i,
    output logic                       fpu_in_valid_o,
    input  logic                       fpu_in_ready_i,
    output logic [REQ_W-1:0]           fpu_req_o,
    output logic [$clog2(NUM_REQ)-1:0] fpu_tag_o,
    input  logic                       fpu_out_valid_i,
    output logic                       fpu_out_ready_o,
    input  logic [$clog2(NUM_REQ)-1:0] fpu_tag_i,
    input  logic [RES_W-1:0]           fpu_res_i,
    output logic                       fpu_flush_o,
    output logic                       busy_o
`ifdef FPNEW_ARB_PERF_EN
    ,
    output logic [NUM_REQ*32-1:0]      perf_grant_o,
    output logic [NUM_REQ*32-1:0]      perf_stall_o
`endif
);

    localparam int unsigned       ID_W        = $clog2(NUM_REQ);
    localparam logic [ID_W:0]     c_num_req   = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0]   c_last_idx  = ID_W'(NUM_REQ - 1);
    localparam logic [3:0]        c_max_outst = 4'(MAX_OUTST);

    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [3:0]         outst_q [NUM_REQ];
    logic [3:0]         outst_d [NUM_REQ];

    logic [NUM_REQ-1:0] eligible;
    logic               gnt_valid;
    logic [ID_W-1:0]    gnt_idx;
    logic [ID_W:0]      scan_sum;
    logic [ID_W-1:0]    scan_idx;
    logic               accept;
    logic               resp_hs;

    // A requester may compete only while it has credit left and no flush is pending
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid_i[i] && (outst_q[i] < c_max_outst) && !flush_i;
        end
    end

    // Round-robin search starting at rr_ptr; scanning offsets high-to-low lets the
    // nearest eligible index overwrite farther ones. The modulo wrap is explicit
    // so non-power-of-two NUM_REQ works.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            scan_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(off);
            if (scan_sum >= c_num_req) begin
                scan_sum = scan_sum - c_num_req;
            end
            scan_idx = scan_sum[ID_W-1:0];
            if (eligible[scan_idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = scan_idx;
            end
        end
    end

    // Combinational pass-through of both handshakes, with flush draining the FPU
    always_comb begin
        fpu_in_valid_o  = gnt_valid;
        fpu_tag_o       = gnt_idx;
        fpu_req_o       = '0;
        req_ready_o     = '0;
        resp_valid_o    = '0;
        fpu_out_ready_o = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == ID_W'(i)) begin
                fpu_req_o      = req_data_i[i*REQ_W +: REQ_W];
                req_ready_o[i] = rst_ni && gnt_valid && fpu_in_ready_i;
            end
            if (fpu_tag_i == ID_W'(i)) begin
                fpu_out_ready_o = resp_ready_i[i];
                resp_valid_o[i] = fpu_out_valid_i;
            end
        end
        if (flush_i) begin
            fpu_out_ready_o = 1'b1;
            resp_valid_o    = '0;
        end
        resp_data_o = fpu_res_i;
        fpu_flush_o = flush_i;
    end

    // Handshake events that move the credit counters and the pointer
    always_comb begin
        accept  = fpu_in_valid_o && fpu_in_ready_i;
        resp_hs = fpu_out_valid_i && fpu_out_ready_o;
    end

    // Next pointer and credits; an accept and a response on the same index cancel
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (gnt_idx == c_last_idx) ? '0 : gnt_idx + 1'b1;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            outst_d[i] = outst_q[i];
            if (flush_i) begin
                outst_d[i] = '0;
            end else begin
                if (accept && gnt_idx == ID_W'(i)) begin
                    outst_d[i] = outst_d[i] + 4'd1;
                end
                if (resp_hs && fpu_tag_i == ID_W'(i)) begin
                    outst_d[i] = outst_d[i] - 4'd1;
                end
            end
        end
    end

    // Pointer and credit registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                outst_q[i] <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                outst_q[i] <= outst_d[i];
            end
        end
    end

    // Busy is derived from registered credits only
    always_comb begin
        busy_o = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (outst_q[i] != 4'd0) begin
                busy_o = 1'b1;
            end
        end
    end

`ifdef FPNEW_ARB_PERF_EN
    logic [31:0] perf_grant_q [NUM_REQ];
    logic [31:0] perf_grant_d [NUM_REQ];
    logic [31:0] perf_stall_q [NUM_REQ];
    logic [31:0] perf_stall_d [NUM_REQ];

    // Count accepts and valid-but-not-ready cycles per requester; flush does not clear them
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            perf_grant_d[i] = perf_grant_q[i];
            perf_stall_d[i] = perf_stall_q[i];
            if (accept && gnt_idx == ID_W'(i)) begin
                perf_grant_d[i] = perf_grant_q[i] + 32'd1;
            end
            if (req_valid_i[i] && !req_ready_o[i]) begin
                perf_stall_d[i] = perf_stall_q[i] + 32'd1;
            end
        end
    end

    // Performance counter registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                perf_grant_q[i] <= '0;
                perf_stall_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                perf_grant_q[i] <= perf_grant_d[i];
                perf_stall_q[i] <= perf_stall_d[i];
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_perf_out
        assign perf_grant_o[gi*32 +: 32] = perf_grant_q[gi];
        assign perf_stall_o[gi*32 +: 32] = perf_stall_q[gi];
    end
`endif

`ifndef SYNTHESIS
    // Credit overflow, credit underflow and out-of-range response tags are integration errors
    always @(posedge clk_i) begin
        if (rst_ni) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                assert (outst_d[i] <= c_max_outst)
                    else $error("outstanding count overflow on requester %0d", i);
                assert (!(resp_hs && !flush_i && fpu_tag_i == ID_W'(i) && outst_q[i] == 4'd0))
                    else $error("response for requester %0d with no operation in flight", i);
            end
            assert (!(fpu_out_valid_i && ({1'b0, fpu_tag_i} >= c_num_req)))
                else $error("response tag out of range");
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fpnew_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpnew_rr_arbiter
// Description : Directed and randomized bench for fpnew_rr_arbiter against a
//               cycle-level model of the arbitration and credit rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpnew_rr_arbiter;
    localparam int N     = 4;
    localparam int REQ_W = 200;
    localparam int RES_W = 69;
    localparam int MAXO  = 4;
    localparam int ID_W  = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [N-1:0]         req_valid, req_ready, resp_valid, resp_ready;
    logic [N*REQ_W-1:0]   req_data;
    logic [RES_W-1:0]     resp_data, fpu_res;
    logic                 flush, fpu_in_valid, fpu_in_ready, fpu_out_valid, fpu_out_ready;
    logic                 fpu_flush, busy;
    logic [REQ_W-1:0]     fpu_req;
    logic [ID_W-1:0]      fpu_tag_o, fpu_tag_i;
`ifdef FPNEW_ARB_PERF_EN
    logic [N*32-1:0]      perf_grant, perf_stall;
`endif

    always #5 clk = ~clk;

    fpnew_rr_arbiter #(
        .NUM_REQ(N), .REQ_W(REQ_W), .RES_W(RES_W), .MAX_OUTST(MAXO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_data_i(req_data),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_data_o(resp_data),
        .flush_i(flush),
        .fpu_in_valid_o(fpu_in_valid), .fpu_in_ready_i(fpu_in_ready),
        .fpu_req_o(fpu_req), .fpu_tag_o(fpu_tag_o),
        .fpu_out_valid_i(fpu_out_valid), .fpu_out_ready_o(fpu_out_ready),
        .fpu_tag_i(fpu_tag_i), .fpu_res_i(fpu_res),
        .fpu_flush_o(fpu_flush), .busy_o(busy)
`ifdef FPNEW_ARB_PERF_EN
        , .perf_grant_o(perf_grant), .perf_stall_o(perf_stall)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    int outst_m [N];
    int ptr_m;
    int grant_m [N];
    int stall_m [N];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check every output against the model, then advance the model
    task automatic step();
        int g;
        int idx;
        int k;
        logic [N-1:0] exp_rdy, exp_rv;
        logic exp_ordy, exp_busy;
        @(negedge clk);
        g = -1;
        for (int off = 0; off < N; off++) begin
            idx = (ptr_m + off) % N;
            if (g < 0 && req_valid[idx] && outst_m[idx] < MAXO && !flush) g = idx;
        end
        exp_rdy = '0;
        if (g >= 0 && fpu_in_ready && rst_n) exp_rdy[g] = 1'b1;
        k = int'(fpu_tag_i);
        exp_rv = '0;
        if (fpu_out_valid && !flush) exp_rv[k] = 1'b1;
        exp_ordy = flush ? 1'b1 : resp_ready[k];
        exp_busy = 1'b0;
        for (int i = 0; i < N; i++) if (outst_m[i] != 0) exp_busy = 1'b1;

        chk("in_valid", 256'(fpu_in_valid), 256'(g >= 0));
        if (g >= 0) begin
            chk("tag_out", 256'(fpu_tag_o), 256'(g));
            chk("req_data", 256'(fpu_req), 256'(req_data[g*REQ_W +: REQ_W]));
        end
        chk("req_ready", 256'(req_ready), 256'(exp_rdy));
        chk("resp_valid", 256'(resp_valid), 256'(exp_rv));
        chk("out_ready", 256'(fpu_out_ready), 256'(exp_ordy));
        chk("resp_data", 256'(resp_data), 256'(fpu_res));
        chk("flush_out", 256'(fpu_flush), 256'(flush));
        chk("busy", 256'(busy), 256'(exp_busy));
`ifdef FPNEW_ARB_PERF_EN
        for (int i = 0; i < N; i++) begin
            chk("perf_grant", 256'(perf_grant[i*32 +: 32]), 256'(32'(grant_m[i])));
            chk("perf_stall", 256'(perf_stall[i*32 +: 32]), 256'(32'(stall_m[i])));
        end
`endif
        @(posedge clk);
        if (!rst_n) begin
            ptr_m = 0;
            for (int i = 0; i < N; i++) begin
                outst_m[i] = 0; grant_m[i] = 0; stall_m[i] = 0;
            end
        end else begin
            for (int i = 0; i < N; i++) if (req_valid[i] && !exp_rdy[i]) stall_m[i]++;
            if (flush) begin
                for (int i = 0; i < N; i++) outst_m[i] = 0;
            end else begin
                if (g >= 0 && fpu_in_ready) begin
                    outst_m[g]++;
                    grant_m[g]++;
                    ptr_m = (g + 1) % N;
                end
                if (fpu_out_valid && exp_ordy) outst_m[k]--;
            end
        end
        #1;
    endtask

    // Offer a legal response from a randomly chosen requester with work in flight
    task automatic pick_resp();
        int cand [$];
        cand = {};
        for (int i = 0; i < N; i++) if (outst_m[i] > 0) cand.push_back(i);
        fpu_res = RES_W'({$urandom(), $urandom(), $urandom()});
        if (cand.size() > 0) begin
            fpu_out_valid = 1'b1;
            fpu_tag_i = ID_W'(cand[$urandom_range(cand.size() - 1, 0)]);
        end else begin
            fpu_out_valid = 1'b0;
            fpu_tag_i = ID_W'($urandom);
        end
    endtask

    task automatic drain();
        req_valid = '0;
        flush = 1'b0;
        resp_ready = '1;
        for (int c = 0; c < 64; c++) begin
            pick_resp();
            if (!fpu_out_valid) break;
            step();
        end
        fpu_out_valid = 1'b0;
        #1;
        chk("drained", 256'(busy), 256'(0));
    endtask

    task automatic rand_data();
        for (int w = 0; w < N*REQ_W/32; w++) req_data[w*32 +: 32] = $urandom;
    endtask

    initial begin
        ptr_m = 0;
        for (int i = 0; i < N; i++) begin
            outst_m[i] = 0; grant_m[i] = 0; stall_m[i] = 0;
        end
        rst_n = 1'b0; req_valid = '1; resp_ready = '1; flush = 1'b0;
        fpu_in_ready = 1'b1; fpu_out_valid = 1'b0; fpu_tag_i = '0; fpu_res = '0;
        rand_data();
        #1;
        chk("rst_ready", 256'(req_ready), 256'(0));
        step(); step();

        // Continuous requests rotate 0,1,2,3,0,1
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            rand_data();
            #1;
            chk("rr_seq", 256'(fpu_tag_o), 256'(c % N));
            chk("rr_ready", 256'(req_ready), 256'(1 << (c % N)));
            step();
        end
        drain();

        // Credit limit on requester 2
        resp_ready = 4'b1011;
        req_valid  = 4'b0100;
        for (int c = 0; c < 4; c++) step();
        req_valid = 4'b0110;
        #1;
        chk("credit_block", 256'(req_ready), 256'(4'b0010));
        step();
        req_valid = 4'b0100; resp_ready = 4'b1111;
        fpu_out_valid = 1'b1; fpu_tag_i = 2'd2;
        #1;
        chk("credit_resp_cycle", 256'(req_ready), 256'(0));
        step();
        fpu_out_valid = 1'b0;
        #1;
        chk("credit_reopen", 256'(req_ready), 256'(4'b0100));
        step();
        drain();

        // Stalled consumer on tag 3
        req_valid = 4'b1000;
        step();
        req_valid = '0; resp_ready = 4'b0111;
        fpu_out_valid = 1'b1; fpu_tag_i = 2'd3;
        #1;
        chk("stall_rv", 256'(resp_valid), 256'(4'b1000));
        chk("stall_ordy", 256'(fpu_out_ready), 256'(0));
        step(); step();
        chk("stall_busy", 256'(busy), 256'(1));
        resp_ready = '1;
        #1;
        chk("unstall_ordy", 256'(fpu_out_ready), 256'(1));
        step();
        fpu_out_valid = 1'b0;
        #1;
        chk("unstall_busy", 256'(busy), 256'(0));
        step();

        // Simultaneous accept and response on requester 1 at outst=2
        req_valid = 4'b0010;
        step(); step();
        fpu_out_valid = 1'b1; fpu_tag_i = 2'd1;
        step();
        req_valid = '0;
        step();
        chk("same_cycle_1", 256'(busy), 256'(1));
        step();
        fpu_out_valid = 1'b0;
        #1;
        chk("same_cycle_2", 256'(busy), 256'(0));
        step();

        // Flush with three operations in flight
        req_valid = 4'b0111;
        step(); step(); step();
        flush = 1'b1; req_valid = '1;
        #1;
        chk("flush_out", 256'(fpu_flush), 256'(1));
        chk("flush_nogrant", 256'(fpu_in_valid), 256'(0));
        chk("flush_ready", 256'(req_ready), 256'(0));
        step();
        flush = 1'b0; req_valid = '0;
        #1;
        chk("flush_busy", 256'(busy), 256'(0));
        step();

`ifdef FPNEW_ARB_PERF_EN
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; req_valid = 4'b0001; fpu_in_ready = 1'b0;
        for (int c = 0; c < 5; c++) step();
        fpu_in_ready = 1'b1;
        step();
        req_valid = '0;
        #1;
        chk("perf_stall0", 256'(perf_stall[31:0]), 256'(5));
        chk("perf_grant0", 256'(perf_grant[31:0]), 256'(1));
        step();
        drain();
`endif

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            rst_n = ($urandom_range(199, 0) != 0);
            req_valid = N'($urandom);
            rand_data();
            fpu_in_ready = ($urandom_range(3, 0) != 0);
            resp_ready = N'($urandom);
            flush = ($urandom_range(31, 0) == 0);
            if ($urandom_range(1, 0) == 1) pick_resp();
            else begin
                fpu_out_valid = 1'b0;
                fpu_tag_i = ID_W'($urandom);
                fpu_res = RES_W'({$urandom(), $urandom(), $urandom()});
            end
            if (!rst_n) fpu_out_valid = 1'b0;
            step();
        end
        rst_n = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
